// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift_seq_reg block.
// - MODE encodings for the universal shift register.
// - FSM state encoding for the multi-cycle shift sequencer.
// - is_shift_mode(): true for modes that move bits (shift, rotate, ASR).
package shift_seq_pkg;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SHL  = 3'b001;
    localparam logic [2:0] M_SHR  = 3'b010;
    localparam logic [2:0] M_LOAD = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    function automatic logic is_shift_mode(input logic [2:0] m);
        return (m == M_SHL) || (m == M_SHR) || (m == M_ROL) ||
               (m == M_ROR) || (m == M_ASR);
    endfunction

endpackage

// File: rtl/shift_seq_reg_shift_op_unit.sv
// shift_op_unit: combinational next-value generator for the shift register.
// Shared by the single-op path and the sequencer path.
// Ports:
//   q      - current register contents
//   mode   - operation select (M_* encodings)
//   sl     - serial bit entering at LSB on shift left
//   sr     - serial bit entering at MSB on shift right
//   d      - parallel load data
//   next_q - value the register takes if this op is applied
module shift_op_unit
    import shift_seq_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int ONES_CLR = 0
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic             sl,
    input  logic             sr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] next_q
);

    always_comb begin
        next_q = q;
        case (mode)
            M_HOLD: next_q = q;
            M_SHL:  next_q = {q[WIDTH-2:0], sl};
            M_SHR:  next_q = {sr, q[WIDTH-1:1]};
            M_LOAD: next_q = d;
            M_ROL:  next_q = {q[WIDTH-2:0], q[WIDTH-1]};
            M_ROR:  next_q = {q[0], q[WIDTH-1:1]};
            M_ASR:  next_q = {q[WIDTH-1], q[WIDTH-1:1]};
            M_CLR:  next_q = '0;
            default: next_q = q;
        endcase
        // Saturated pattern collapses to zero on any bit-moving op.
        if ((ONES_CLR != 0) && is_shift_mode(mode) && (&q))
            next_q = '0;
    end

endmodule

// File: rtl/shift_seq_reg.sv
// shift_seq_reg: universal shift register with a multi-cycle shift sequencer.
// Ports:
//   CLK, CLR      - clock and synchronous active-high reset (CLR wins over all)
//   EN, MODE      - single-op enable and operation select (IDLE only)
//   SL, SR        - serial inputs for shift left / shift right
//   D             - parallel load data
//   START, NSHIFT - request an NSHIFT-step sequence of the selected shift mode
//   Q             - register contents
//   SO_L, SO_R    - serial outputs Q[WIDTH-1] / Q[0]
//   BUSY, DONE    - sequence in progress / one-cycle completion pulse
module shift_seq_reg
    import shift_seq_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CNT_W    = 4,
    parameter int ONES_CLR = 0
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             EN,
    input  logic [2:0]       MODE,
    input  logic             SL,
    input  logic             SR,
    input  logic [WIDTH-1:0] D,
    input  logic             START,
    input  logic [CNT_W-1:0] NSHIFT,
    output logic [WIDTH-1:0] Q,
    output logic             SO_L,
    output logic             SO_R,
    output logic             BUSY,
    output logic             DONE
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;

    logic [2:0]       op_mode;
    logic [WIDTH-1:0] op_q;

    // During a sequence the latched mode drives the op unit; SL/SR stay live.
    assign op_mode = (state_q == S_RUN) ? mode_q : MODE;

    shift_op_unit #(
        .WIDTH    (WIDTH),
        .ONES_CLR (ONES_CLR)
    ) u_op (
        .q      (q_q),
        .mode   (op_mode),
        .sl     (SL),
        .sr     (SR),
        .d      (D),
        .next_q (op_q)
    );

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    if (is_shift_mode(MODE)) begin
                        // Sequence arms here; the first shift lands on the next edge.
                        mode_d  = MODE;
                        cnt_d   = NSHIFT;
                        state_d = (NSHIFT != '0) ? S_RUN : S_FIN;
                    end else begin
                        q_d     = op_q;
                        state_d = S_FIN;
                    end
                end else if (EN) begin
                    q_d = op_q;
                end
            end
            S_RUN: begin
                q_d   = op_q;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1))
                    state_d = S_FIN;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            mode_q  <= M_HOLD;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    assign Q    = q_q;
    assign SO_L = q_q[WIDTH-1];
    assign SO_R = q_q[0];
    assign BUSY = (state_q == S_RUN);
    assign DONE = (state_q == S_FIN);

endmodule

// File: tb/tb_shift_seq_reg.sv
module tb_shift_seq_reg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             clr;
    logic             en;
    logic [2:0]       mode;
    logic             sl;
    logic             sr;
    logic [WIDTH-1:0] d;
    logic             start;
    logic [CNT_W-1:0] nshift;

    logic [WIDTH-1:0] q0, q1;
    logic             so_l0, so_r0, busy0, done0;
    logic             so_l1, so_r1, busy1, done1;

    int total;
    int bad;

    shift_seq_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ONES_CLR(0)) dut (
        .CLK(clk), .CLR(clr), .EN(en), .MODE(mode), .SL(sl), .SR(sr), .D(d),
        .START(start), .NSHIFT(nshift), .Q(q0), .SO_L(so_l0), .SO_R(so_r0),
        .BUSY(busy0), .DONE(done0)
    );

    shift_seq_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ONES_CLR(1)) dut_oc (
        .CLK(clk), .CLR(clr), .EN(en), .MODE(mode), .SL(sl), .SR(sr), .D(d),
        .START(start), .NSHIFT(nshift), .Q(q1), .SO_L(so_l1), .SO_R(so_r1),
        .BUSY(busy1), .DONE(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge; inputs and samples both sit 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
        chk({tag, ".Q"}, 32'(q0), 32'(eq));
        chk({tag, ".BUSY"}, 32'(busy0), 32'(eb));
        chk({tag, ".DONE"}, 32'(done0), 32'(ed));
    endtask

    task automatic load(input logic [7:0] v);
        en = 1'b1; start = 1'b0; mode = 3'b011; d = v;
        step();
        en = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0;
        clr = 1'b1; en = 1'b0; mode = 3'b000; sl = 1'b0; sr = 1'b0;
        d = '0; start = 1'b0; nshift = '0;
        #1;
        step();
        step();
        clr = 1'b0;
        chk_st("reset", 8'h00, 1'b0, 1'b0);
        chk("reset.oc.Q", 32'(q1), 32'h0);

        // 1: load and rotate left
        load(8'hA5);
        chk_st("load_a5", 8'hA5, 1'b0, 1'b0);
        en = 1'b1; mode = 3'b100;
        step();
        chk_st("rol", 8'h4B, 1'b0, 1'b0);
        chk("rol.SO_L", 32'(so_l0), 32'h0);
        chk("rol.SO_R", 32'(so_r0), 32'h1);
        mode = 3'b000;
        step();
        chk("hold.Q", 32'(q0), 32'h4B);

        // 2: shift left / right / ASR
        load(8'hA5);
        en = 1'b1; mode = 3'b001; sl = 1'b1;
        step();
        chk("shl.Q", 32'(q0), 32'h4B);
        load(8'hA5);
        en = 1'b1; mode = 3'b010; sr = 1'b0;
        step();
        chk("shr.Q", 32'(q0), 32'h52);
        load(8'h80);
        en = 1'b1; mode = 3'b110;
        step();
        chk("asr.Q", 32'(q0), 32'hC0);
        chk("asr.SO_L", 32'(so_l0), 32'h1);
        en = 1'b1; mode = 3'b111;
        step();
        chk("clr_mode.Q", 32'(q0), 32'h00);
        en = 1'b0; sl = 1'b0;

        // 3: three-step rotate-right sequence, with noise during RUN
        load(8'h81);
        start = 1'b1; mode = 3'b101; nshift = 4'd3;
        step();
        chk_st("seq.arm", 8'h81, 1'b1, 1'b0);
        start = 1'b1; en = 1'b1; mode = 3'b011; d = 8'h00; nshift = 4'd9;
        step();
        chk_st("seq.s1", 8'hC0, 1'b1, 1'b0);
        start = 1'b0; en = 1'b0;
        step();
        chk_st("seq.s2", 8'h60, 1'b1, 1'b0);
        step();
        chk_st("seq.s3", 8'h30, 1'b0, 1'b1);
        step();
        chk_st("seq.idle", 8'h30, 1'b0, 1'b0);

        // 4: zero-length sequence, then START with a non-shift mode
        start = 1'b1; mode = 3'b001; nshift = 4'd0; sl = 1'b1;
        step();
        chk_st("n0.fin", 8'h30, 1'b0, 1'b1);
        start = 1'b0;
        step();
        chk_st("n0.idle", 8'h30, 1'b0, 1'b0);
        start = 1'b1; mode = 3'b011; d = 8'h3C;
        step();
        chk_st("startld.fin", 8'h3C, 1'b0, 1'b1);
        start = 1'b0;
        step();
        chk_st("startld.idle", 8'h3C, 1'b0, 1'b0);

        // 5: abort a sequence with CLR, then restart
        load(8'hFF);
        start = 1'b1; mode = 3'b001; nshift = 4'd5; sl = 1'b0;
        step();
        start = 1'b0;
        chk_st("abort.arm", 8'hFF, 1'b1, 1'b0);
        step();
        chk_st("abort.s1", 8'hFE, 1'b1, 1'b0);
        step();
        chk_st("abort.s2", 8'hFC, 1'b1, 1'b0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk_st("abort.clr", 8'h00, 1'b0, 1'b0);
        step();
        chk_st("abort.after", 8'h00, 1'b0, 1'b0);
        load(8'h5A);
        start = 1'b1; mode = 3'b101; nshift = 4'd1;
        step();
        start = 1'b0;
        chk_st("restart.arm", 8'h5A, 1'b1, 1'b0);
        step();
        chk_st("restart.s1", 8'h2D, 1'b0, 1'b1);
        step();

        // 6: all-ones behaviour on both parameterisations
        load(8'hFF);
        chk("ones.ld.Q", 32'(q0), 32'hFF);
        chk("ones.ld.oc.Q", 32'(q1), 32'hFF);
        en = 1'b1; mode = 3'b001; sl = 1'b1;
        step();
        en = 1'b0;
        chk("ones.shl.Q", 32'(q0), 32'hFF);
        chk("ones.shl.oc.Q", 32'(q1), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
